// File: rtl/data_bus_responder_pkg.sv
// Shared constants, types and helpers for the data-bus responder and its timer.
package data_bus_responder_pkg;

    localparam int          DEFAULT_DM_WORDS   = 3072;
    localparam logic [31:0] DEFAULT_TIMER_BASE = 32'h0000_7F00;

    // Byte offsets of the timer registers from the timer base
    localparam logic [31:0] CTRL_OFF   = 32'h0000_0000;
    localparam logic [31:0] PRESET_OFF = 32'h0000_0004;
    localparam logic [31:0] COUNT_OFF  = 32'h0000_0008;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM       = 3;

    // MODE encodings; 2'b1x is reserved and treated as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_t;

    typedef enum logic [1:0] {
        SEL_CTRL   = 2'd0,
        SEL_PRESET = 2'd1,
        SEL_COUNT  = 2'd2,
        SEL_NONE   = 2'd3
    } reg_sel_t;

    // First byte address past the RAM region
    function automatic logic [31:0] ram_limit(input int words);
        return 32'(4 * words);
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_bus_responder_timer_core.sv
// Count-down timer: CTRL/PRESET/COUNT registers, sequencing FSM and interrupt flag.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped, waiting for EN
//   LOAD  | copy PRESET into COUNT
//   CNT   | decrement COUNT each cycle; leave on EN=0 or COUNT==0
//   INT   | terminal count reached; one-shot clears EN, reload goes LOAD
module timer_core
    import data_bus_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  reg_sel_t    reg_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] ctrl_rd,
    output logic [31:0] preset_rd,
    output logic [31:0] count_rd,
    output logic        irq
);

    timer_state_t state_q, state_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [31:0]  preset_q;
    logic [31:0]  count_q, count_d;
    logic         irq_flag_q, irq_flag_d;
    logic         ctrl_wr;
    logic         preset_wr;
    logic         en;
    logic         mode_reload;

    assign ctrl_wr     = wr_en && (reg_sel == SEL_CTRL);
    assign preset_wr   = wr_en && (reg_sel == SEL_PRESET);
    assign en          = ctrl_q[CTRL_EN];
    assign mode_reload = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

    // FSM, COUNT, CTRL and interrupt-flag state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // PRESET only changes on a CPU write; COUNT picks it up at the next LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset_q <= '0;
        end else if (preset_wr) begin
            preset_q <= wr_data;
        end
    end

    // Next-state logic; a CPU CTRL write overrides the INT-state EN clear
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    state_d    = ST_INT;
                    irq_flag_d = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (mode_reload) begin
                    state_d    = ST_LOAD;
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_wr) begin
            ctrl_d = wr_data[3:0];
            // a write landing on the very edge that enters INT must not hide that event
            if (state_d != ST_INT) irq_flag_d = 1'b0;
        end
    end

    assign ctrl_rd   = {28'd0, ctrl_q};
    assign preset_rd = preset_q;
    assign count_rd  = count_q;
    assign irq       = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: word RAM with byte-lane writes plus a memory-mapped timer.
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DM_WORDS   = DEFAULT_DM_WORDS,
    parameter logic [31:0] TIMER_BASE = DEFAULT_TIMER_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int          IDX_W     = $clog2(DM_WORDS);
    localparam logic [31:0] RAM_LIMIT = ram_limit(DM_WORDS);

    logic [31:0]      ram [DM_WORDS];
    logic [31:0]      word_addr;
    logic [IDX_W-1:0] ram_idx;
    logic             hit_ram;
    logic             ram_wr;
    reg_sel_t         reg_sel;
    logic             timer_wr;
    logic [31:0]      ctrl_rd;
    logic [31:0]      preset_rd;
    logic [31:0]      count_rd;

    assign word_addr = {m_data_addr[31:2], 2'b00};
    assign hit_ram   = (m_data_addr < RAM_LIMIT);
    assign ram_idx   = m_data_addr[IDX_W+1:2];
    assign ram_wr    = hit_ram && (m_data_byteen != 4'b0000);

    // Timer register decode; RAM takes priority should the regions ever overlap
    always_comb begin
        reg_sel = SEL_NONE;
        if (!hit_ram) begin
            if (word_addr == TIMER_BASE + CTRL_OFF)        reg_sel = SEL_CTRL;
            else if (word_addr == TIMER_BASE + PRESET_OFF) reg_sel = SEL_PRESET;
            else if (word_addr == TIMER_BASE + COUNT_OFF)  reg_sel = SEL_COUNT;
        end
    end

    // Timer registers only accept full-word writes; COUNT is read-only
    assign timer_wr = (m_data_byteen == 4'b1111) &&
                      (reg_sel == SEL_CTRL || reg_sel == SEL_PRESET);

    // RAM array: cleared on reset, byte-lane merge on write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) ram[i] <= '0;
        end else if (ram_wr) begin
            ram[ram_idx] <= merge_bytes(ram[ram_idx], m_data_wdata, m_data_byteen);
        end
    end

    timer_core u_timer_core (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (timer_wr),
        .reg_sel   (reg_sel),
        .wr_data   (m_data_wdata),
        .ctrl_rd   (ctrl_rd),
        .preset_rd (preset_rd),
        .count_rd  (count_rd),
        .irq       (irq)
    );

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        m_data_rdata = 32'd0;
        if (hit_ram) begin
            m_data_rdata = ram[ram_idx];
        end else begin
            case (reg_sel)
                SEL_CTRL:   m_data_rdata = ctrl_rd;
                SEL_PRESET: m_data_rdata = preset_rd;
                SEL_COUNT:  m_data_rdata = count_rd;
                default:    m_data_rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder.
module tb_data_bus_responder;

    localparam logic [31:0] T_BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = T_BASE;
    localparam logic [31:0] A_PRESET = T_BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = T_BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic        irq;

    int pass_cnt  = 0;
    int check_cnt = 0;

    data_bus_responder #(
        .DM_WORDS   (3072),
        .TIMER_BASE (32'h0000_7F00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // write completes on a rising edge; returns 1ns after that edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        @(posedge clk);
        #1;
        m_data_byteen = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        m_data_addr   = a;
        m_data_byteen = 4'b0000;
        #1;
        d = m_data_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset         = 1'b0;
        m_data_addr   = 32'd0;
        m_data_wdata  = 32'd0;
        m_data_byteen = 4'b0000;
        #12;
        check_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        bus_read(32'h10, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL reset_ram: got %h want 00000000", d);
        else pass_cnt++;
        bus_read(A_CTRL, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL reset_ctrl: got %h want 00000000", d);
        else pass_cnt++;
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL reset_count: got %h want 00000000", d);
        else pass_cnt++;
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        bus_write(32'h10, 32'hAABBCCDD, 4'b1111);
        @(negedge clk);
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'h11223344;
        m_data_byteen = 4'b0010;
        #1;
        check_cnt++;
        if (m_data_rdata !== 32'hAABBCCDD)
            $display("FAIL same_cycle_read: got %h want aabbccdd", m_data_rdata);
        else pass_cnt++;
        @(posedge clk);
        #1;
        m_data_byteen = 4'b0000;
        bus_read(32'h10, d);
        check_cnt++;
        if (d !== 32'hAABB33DD) $display("FAIL byte_lane_merge: got %h want aabb33dd", d);
        else pass_cnt++;
        bus_write(32'h0, 32'h12345678, 4'b1001);
        bus_read(32'h0, d);
        check_cnt++;
        if (d !== 32'h12000078) $display("FAIL byte_lane_outer: got %h want 12000078", d);
        else pass_cnt++;
        bus_write(32'h2FFC, 32'hCAFEF00D, 4'b1111);
        bus_read(32'h2FFC, d);
        check_cnt++;
        if (d !== 32'hCAFEF00D) $display("FAIL ram_last_word: got %h want cafef00d", d);
        else pass_cnt++;
        bus_write(32'h3000, 32'hDEADBEEF, 4'b1111);
        bus_read(32'h3000, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL ram_past_end: got %h want 00000000", d);
        else pass_cnt++;
    endtask

    task automatic test_unmapped_partial();
        logic [31:0] d;
        bus_write(A_PRESET, 32'h0000_0055, 4'b0011);
        bus_read(A_PRESET, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL partial_preset: got %h want 00000000", d);
        else pass_cnt++;
        bus_write(32'h4000, 32'h12345678, 4'b1111);
        bus_read(32'h4000, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL unmapped_read: got %h want 00000000", d);
        else pass_cnt++;
        bus_write(A_COUNT, 32'h77, 4'b1111);
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL count_readonly: got %h want 00000000", d);
        else pass_cnt++;
        bus_write(A_CTRL, 32'h9, 4'b1110);
        bus_read(A_CTRL, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL partial_ctrl: got %h want 00000000", d);
        else pass_cnt++;
        bus_write(A_PRESET, 32'hABCD1234, 4'b1111);
        bus_read(A_PRESET, d);
        check_cnt++;
        if (d !== 32'hABCD1234) $display("FAIL preset_full_write: got %h want abcd1234", d);
        else pass_cnt++;
    endtask

    task automatic test_one_shot();
        logic [31:0] d;
        int k;
        bus_write(A_PRESET, 32'd5, 4'b1111);
        bus_write(A_CTRL, 32'h9, 4'b1111);
        k = 0;
        while (irq !== 1'b1 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_cnt++;
        if (k !== 8) $display("FAIL oneshot_latency: got %0d cycles want 8", k);
        else pass_cnt++;
        repeat (5) @(posedge clk);
        #1;
        check_cnt++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_sticky: got %b want 1", irq);
        else pass_cnt++;
        bus_read(A_CTRL, d);
        check_cnt++;
        if (d !== 32'h8) $display("FAIL oneshot_ctrl_en_clear: got %h want 00000008", d);
        else pass_cnt++;
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd0) $display("FAIL oneshot_count_end: got %h want 00000000", d);
        else pass_cnt++;
        bus_write(A_CTRL, 32'h0, 4'b1111);
        check_cnt++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_clear: got %b want 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_preset_zero();
        int k;
        bus_write(A_PRESET, 32'd0, 4'b1111);
        bus_write(A_CTRL, 32'h9, 4'b1111);
        k = 0;
        while (irq !== 1'b1 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_cnt++;
        if (k !== 3) $display("FAIL preset_zero_latency: got %0d cycles want 3", k);
        else pass_cnt++;
        bus_write(A_CTRL, 32'h0, 4'b1111);
    endtask

    task automatic test_auto_reload();
        logic [31:0] cnt_at [0:19];
        logic        irq_at [0:19];
        int first;
        int pulses;
        bus_write(A_PRESET, 32'd3, 4'b1111);
        bus_write(A_CTRL, 32'hB, 4'b1111);
        m_data_addr = A_COUNT;
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1;
            cnt_at[k] = m_data_rdata;
            irq_at[k] = irq;
            if (irq === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        check_cnt++;
        if (first !== 6) $display("FAIL reload_first_irq: got %0d want 6", first);
        else pass_cnt++;
        check_cnt++;
        if (pulses !== 3) $display("FAIL reload_pulse_count: got %0d want 3", pulses);
        else pass_cnt++;
        check_cnt++;
        if (irq_at[7] !== 1'b0 || irq_at[12] !== 1'b1)
            $display("FAIL reload_pulse_shape: got k7=%b k12=%b want 0 1", irq_at[7], irq_at[12]);
        else pass_cnt++;
        check_cnt++;
        if ({cnt_at[2], cnt_at[3], cnt_at[4], cnt_at[5]} !== {32'd3, 32'd2, 32'd1, 32'd0})
            $display("FAIL reload_count_seq: got %0d,%0d,%0d,%0d want 3,2,1,0",
                     cnt_at[2], cnt_at[3], cnt_at[4], cnt_at[5]);
        else pass_cnt++;
        check_cnt++;
        if (cnt_at[8] !== 32'd3) $display("FAIL reload_count_reload: got %0d want 3", cnt_at[8]);
        else pass_cnt++;
        bus_write(A_CTRL, 32'h0, 4'b1111);
        repeat (4) @(posedge clk);
    endtask

    task automatic test_disable_mid();
        logic [31:0] d;
        logic        saw_irq;
        bus_write(A_PRESET, 32'd10, 4'b1111);
        bus_write(A_CTRL, 32'h9, 4'b1111);
        repeat (3) @(posedge clk);
        bus_write(A_CTRL, 32'h0, 4'b1111);
        saw_irq = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (irq === 1'b1) saw_irq = 1'b1;
        end
        check_cnt++;
        if (saw_irq !== 1'b0) $display("FAIL disable_no_irq: got %b want 0", saw_irq);
        else pass_cnt++;
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd8) $display("FAIL disable_count_frozen: got %0d want 8", d);
        else pass_cnt++;
        repeat (5) @(posedge clk);
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd8) $display("FAIL disable_count_hold: got %0d want 8", d);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int k;
        bus_write(A_PRESET, 32'd4, 4'b1111);
        bus_write(A_CTRL, 32'hB, 4'b1111);
        k = 0;
        while (irq !== 1'b1 && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_cnt++;
        if (k !== 7) $display("FAIL areset_setup_irq: got %0d cycles want 7", k);
        else pass_cnt++;
        #1;
        reset = 1'b0;
        #1;
        check_cnt++;
        if (irq !== 1'b0) $display("FAIL areset_irq: got %b want 0", irq);
        else pass_cnt++;
        m_data_addr = A_CTRL;
        #1;
        check_cnt++;
        if (m_data_rdata !== 32'd0) $display("FAIL areset_ctrl: got %h want 00000000", m_data_rdata);
        else pass_cnt++;
        m_data_addr = A_PRESET;
        #1;
        check_cnt++;
        if (m_data_rdata !== 32'd0) $display("FAIL areset_preset: got %h want 00000000", m_data_rdata);
        else pass_cnt++;
        m_data_addr = 32'h10;
        #1;
        check_cnt++;
        if (m_data_rdata !== 32'd0) $display("FAIL areset_ram: got %h want 00000000", m_data_rdata);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(posedge clk);
        bus_read(A_COUNT, d);
        check_cnt++;
        if (d !== 32'd0 || irq !== 1'b0)
            $display("FAIL areset_stays_idle: got count=%0d irq=%b want 0 0", d, irq);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_byte_lanes();
        test_unmapped_partial();
        test_one_shot();
        test_preset_zero();
        test_auto_reload();
        test_disable_mid();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
